// File: rtl/imem_loader_pkg.sv
// Shared processor package: ALU control encodings plus the boot-loader FSM
// state encoding and boot-stream framing constants.
package imem_loader_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [2:0] ST_LEN   = 3'd0;
  localparam logic [2:0] ST_DATA  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_CHK   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  // Stream framing: length byte first, then little-endian 32-bit words.
  localparam int LEN_BYTE_POS   = 0;
  localparam int BYTES_PER_WORD = 4;

  // Byte acceptance is a pure function of state, never of rx_valid.
  function automatic logic st_rx_ready(input logic [2:0] st);
    return (st == ST_LEN) || (st == ST_DATA) || (st == ST_CHK);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> instruction-memory words, then releases the core.
// Latency: 4 bytes + 1 write cycle per word; backpressure: rx_ready low in WRITE/DONE/ERR.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          core_run,
  output logic          load_err
);

  logic [2:0]  state;
  logic [AW:0] word_cnt;
  logic [AW:0] n_words;
  logic [1:0]  byte_cnt;
  logic [31:0] asm_word;
  logic [7:0]  csum;
  logic        rx_fire;
  logic        len_too_big;

  assign rx_ready    = st_rx_ready(state);
  assign rx_fire     = rx_valid && rx_ready;
  assign len_too_big = {24'd0, rx_data} > 32'(DEPTH);

  assign imem_we    = (state == ST_WRITE);
  assign imem_addr  = imem_we ? word_cnt[AW-1:0] : '0;
  assign imem_wdata = imem_we ? asm_word : '0;
  assign core_run   = (state == ST_DONE);
  assign load_err   = (state == ST_ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_LEN;
      word_cnt <= '0;
      n_words  <= '0;
      byte_cnt <= '0;
      asm_word <= '0;
      csum     <= '0;
    end else begin
      case (state)
        ST_LEN: begin
          if (rx_fire) begin
            word_cnt <= '0;
            byte_cnt <= '0;
            csum     <= '0;
            n_words  <= (AW+1)'(rx_data);
            if (rx_data == 8'd0)  state <= ST_CHK;
            else if (len_too_big) state <= ST_ERR;
            else                  state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (rx_fire) begin
            asm_word[{byte_cnt, 3'b000} +: 8] <= rx_data;
            csum     <= csum ^ rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'(BYTES_PER_WORD - 1)) state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (word_cnt == n_words - 1'b1) begin
            state <= ST_CHK;
          end else begin
            word_cnt <= word_cnt + 1'b1;
            state    <= ST_DATA;
          end
        end
        ST_CHK: begin
          if (rx_fire) state <= (rx_data == csum) ? ST_DONE : ST_ERR;
        end
        ST_DONE: state <= ST_DONE;
        ST_ERR:  state <= ST_ERR;
        default: state <= ST_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table-driven protocol cases, randomized streams against
// a stream-parsing model, and asynchronous-reset sequences.
module tb_imem_loader;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_run;
  logic          load_err;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_run  (core_run),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int idle_viol = 0;
  int ready_in_write = 0;

  logic [37:0] got_q[$];   // {addr, data} of every observed write
  logic [37:0] exp_q[$];
  logic [7:0]  tx_q[$];
  bit          exp_done, exp_err;
  int          exp_consume;

  always @(negedge clk) begin
    if (imem_we) got_q.push_back({imem_addr, imem_wdata});
    else if (imem_addr != '0 || imem_wdata != '0) idle_viol++;
    if (imem_we && rx_ready) ready_in_write++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
  endtask

  // Offer the first cnt bytes of tx_q; rnd toggles rx_valid randomly.
  task automatic send(input int cnt, input bit rnd);
    int idx = 0;
    int guard = 0;
    bit acc;
    while (idx < cnt && guard < 20000) begin
      @(negedge clk);
      guard++;
      rx_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rx_data  = rx_valid ? tx_q[idx] : 8'($urandom);
      acc = rx_valid && rx_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    #1 rx_valid = 1'b0;
    chk("send_bytes_accepted", idx, cnt);
  endtask

  // Reference: parse the boot stream as a whole.
  task automatic model();
    int n;
    logic [7:0] x;
    logic [31:0] w;
    exp_q.delete();
    n = tx_q[0];
    if (n > DEPTH) begin
      exp_done = 0; exp_err = 1; exp_consume = 1;
      return;
    end
    x = 8'd0;
    for (int i = 0; i < n; i++) begin
      w = {tx_q[4*i+4], tx_q[4*i+3], tx_q[4*i+2], tx_q[4*i+1]};
      x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      exp_q.push_back({6'(i), w});
    end
    exp_consume = 4*n + 2;
    exp_done = (tx_q[4*n+1] == x);
    exp_err  = !exp_done;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_nwrites"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_write"}, got_q[i], exp_q[i]);
    chk({tag, "_core_run"}, core_run, exp_done);
    chk({tag, "_load_err"}, load_err, exp_err);
    chk({tag, "_rx_ready"}, rx_ready, 0);
  endtask

  typedef struct {
    string       name;
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          bad;
    int          exp_writes;
    bit          exp_run;
    bit          exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0] x;
    logic [31:0] w;
    int n;
    bit bad;

    vecs[0] = '{"two_words",   2,  32'h00500093, 32'h00A00113, 0, 2, 1, 0};
    vecs[1] = '{"bad_csum",    1,  32'h00500093, 32'h0,        1, 1, 0, 1};
    vecs[2] = '{"len_65",      65, 32'h0,        32'h0,        0, 0, 0, 1};
    vecs[3] = '{"len_0",       0,  32'h0,        32'h0,        0, 0, 1, 0};
    vecs[4] = '{"len_0_bad",   0,  32'h0,        32'h0,        1, 0, 0, 1};
    vecs[5] = '{"len_255",     255,32'h0,        32'h0,        0, 0, 0, 1};

    do_reset();
    #1;
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_core_run", core_run, 0);
    chk("rst_load_err", load_err, 0);

    foreach (vecs[v]) begin
      do_reset();
      tx_q.delete();
      tx_q.push_back(8'(vecs[v].n));
      x = 8'd0;
      if (vecs[v].n <= DEPTH) begin
        for (int i = 0; i < vecs[v].n; i++) begin
          w = (i == 0) ? vecs[v].w0 : vecs[v].w1;
          for (int b = 0; b < 4; b++) begin
            tx_q.push_back(w[8*b +: 8]);
            x = x ^ w[8*b +: 8];
          end
        end
        tx_q.push_back(x ^ (vecs[v].bad ? 8'hFF : 8'h00));
      end
      send(tx_q.size(), 0);
      @(negedge clk); #1;
      chk({vecs[v].name, "_nwrites"}, got_q.size(), vecs[v].exp_writes);
      if (got_q.size() > 0) chk({vecs[v].name, "_w0"}, got_q[0], {6'd0, vecs[v].w0});
      if (got_q.size() > 1) chk({vecs[v].name, "_w1"}, got_q[1], {6'd1, vecs[v].w1});
      chk({vecs[v].name, "_core_run"}, core_run, vecs[v].exp_run);
      chk({vecs[v].name, "_load_err"}, load_err, vecs[v].exp_err);
      chk({vecs[v].name, "_rx_ready"}, rx_ready, 0);
    end

    // Randomized streams with rx_valid toggling; run 0 is the full-depth load.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      n   = (r == 0) ? DEPTH : (r == 1) ? 1 : int'($urandom_range(0, 70));
      bad = (r > 1) && ($urandom_range(0, 3) == 0);
      tx_q.delete();
      tx_q.push_back(8'(n));
      x = 8'd0;
      if (n <= DEPTH) begin
        for (int i = 0; i < 4*n; i++) begin
          tx_q.push_back(8'($urandom));
          x = x ^ tx_q[tx_q.size()-1];
        end
        tx_q.push_back(x ^ (bad ? 8'($urandom_range(1, 255)) : 8'h00));
      end
      model();
      send(exp_consume, 1);
      @(negedge clk); #1;
      check_model($sformatf("rand%0d", r));
    end

    // Async reset from DONE drops core_run without a clock edge.
    do_reset();
    tx_q.delete();
    tx_q.push_back(8'd0);
    tx_q.push_back(8'd0);
    send(2, 0);
    @(negedge clk); #1;
    chk("pre_rst_core_run", core_run, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_core_run", core_run, 0);
    chk("async_rst_rx_ready", rx_ready, 1);
    @(negedge clk) rst_n = 1'b1;

    // Reset after two data bytes: partial word abandoned, fresh stream loads.
    do_reset();
    tx_q.delete();
    tx_q.push_back(8'd1);
    tx_q.push_back(8'h78); tx_q.push_back(8'h56);
    tx_q.push_back(8'h34); tx_q.push_back(8'h12);
    tx_q.push_back(8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12);
    send(3, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midload_rst_imem_we", imem_we, 0);
    chk("midload_rst_core_run", core_run, 0);
    chk("midload_rst_load_err", load_err, 0);
    chk("midload_rst_rx_ready", rx_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midload_no_write", got_q.size(), 0);
    send(6, 0);
    @(negedge clk); #1;
    chk("reload_nwrites", got_q.size(), 1);
    if (got_q.size() > 0) chk("reload_word", got_q[0], {6'd0, 32'h12345678});
    chk("reload_core_run", core_run, 1);
    chk("reload_load_err", load_err, 0);

    chk("idle_addr_data_zero", idle_viol, 0);
    chk("no_rx_ready_in_write", ready_in_write, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
